// File: rtl/serial_addsub_if.sv
// serial_addsub_if: bundle of the request/response signals of serial_addsub.
//
// Handshake: the master raises start with sub/a/b valid. The slave samples
// the request only while busy is low, so start and busy together act as the
// valid/ready pair. The request is taken at the first rising edge where
// start=1 and busy=0. Requests made while busy=1 are dropped, not queued.
// done pulses for one cycle when result/carry_out/overflow have been updated.
// Those three outputs then hold until the next done. ser_out/ser_valid
// stream each result bit LSB-first as it is computed.
//
// Signals:
//   start, sub, a, b        master -> slave  request and operands
//   busy, done              slave -> master  handshake status
//   result, carry_out,      slave -> master  registered result and flags
//   overflow
//   ser_out, ser_valid      slave -> master  serial result stream
//   dbg_state               slave -> master  FSM state (0 idle, 1 shifting)
interface serial_addsub_if #(
  parameter int WIDTH = 23
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             ser_out;
  logic             ser_valid;
  logic             dbg_state;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow, ser_out, ser_valid, dbg_state
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow, ser_out, ser_valid, dbg_state
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB-first, one bit per clock.
//
// Operands are loaded in parallel when the block is idle. They then pass
// through a single full adder and a carry flip-flop, one bit per clock.
// The result is returned in parallel with carry/borrow and signed overflow
// flags. Each result bit is also streamed out serially as it is produced.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_addsub_if.slave (start/sub/a/b in; busy/done/result/flags,
//          serial stream and FSM debug state out)
module serial_addsub #(
  parameter  int WIDTH = 23,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN   = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;       // carry into the MSB
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic [1:0]       fa;                   // {carry, sum} of the single full adder

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      cmsb_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      cmsb_q      <= cmsb_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  always_comb begin
    fa          = {1'b0, a_sh_q[0]} + {1'b0, b_sh_q[0]} + {1'b0, carry_q};
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    count_d     = count_q;
    carry_d     = carry_q;
    cmsb_d      = cmsb_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_sh_d  = bus.a;
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          count_d = '0;
          cmsb_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Sum bits enter at the top of A_sh, so after WIDTH shifts it
        // holds the complete result in order.
        a_sh_d      = {fa[0], a_sh_q[WIDTH-1:1]};
        b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d     = fa[1];
        ser_out_d   = fa[0];
        ser_valid_d = 1'b1;
        count_d     = count_q + CW'(1);
        if (count_q == MSB_IN) begin
          cmsb_d = fa[1];
        end
        if (count_q == LAST_BIT) begin
          state_d     = S_IDLE;
          result_d    = {fa[0], a_sh_q[WIDTH-1:1]};
          carry_out_d = fa[1];
          overflow_d  = cmsb_q ^ fa[1];
          done_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub at WIDTH 23, 8 and 2.
// Expected results are pushed when a request is driven and popped on done.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(23)) if23 ();
  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(2))  if2 ();

  serial_addsub #(.WIDTH(23)) dut23 (.clk(clk), .rst_n(rst_n), .bus(if23.slave));
  serial_addsub #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_addsub #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  // Expected entries are {overflow, carry_out, result[63:0]}.
  logic [65:0] exp23_q[$];
  logic [65:0] exp8_q[$];
  logic [65:0] exp2_q[$];
  longint      cyc23_q[$];
  longint      cyc8_q[$];
  longint      cyc2_q[$];

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic done on whole words, independent of bit-serial form.
  function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic s);
    logic [64:0] mask, aa, bb, full;
    logic [63:0] res;
    logic        c, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full = aa + bb + {64'd0, s};
    res  = full[63:0] & mask[63:0];
    c    = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
    return {ov, c, res};
  endfunction

  // ---------------- monitors / scoreboard ----------------
  logic [22:0] ser_acc;
  int          ser_n;
  logic [65:0] e23, e8, e2;
  longint      c23, c8, c2;

  always @(negedge clk) begin
    if (!rst_n) begin
      ser_acc = '0;
      ser_n   = 0;
    end else begin
      if (if23.ser_valid) begin
        ser_acc = {if23.ser_out, ser_acc[22:1]};
        ser_n++;
      end
      if (if23.done) begin
        if (exp23_q.size() == 0) begin
          check("unexp_done23", 66'(if23.done), 66'd0);
        end else begin
          e23 = exp23_q.pop_front();
          c23 = cyc23_q.pop_front();
          check("result23", 66'(if23.result), 66'(e23[22:0]));
          check("carry23", 66'(if23.carry_out), 66'(e23[64]));
          check("ovf23", 66'(if23.overflow), 66'(e23[65]));
          check("done_cycle23", 66'(cyc), 66'(c23));
          check("ser_bits23", 66'(ser_acc), 66'(e23[22:0]));
          check("ser_count23", 66'(ser_n), 66'd23);
          check("busy_in_done23", 66'(if23.busy), 66'd0);
        end
        ser_n = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if8.done) begin
      if (exp8_q.size() == 0) begin
        check("unexp_done8", 66'(if8.done), 66'd0);
      end else begin
        e8 = exp8_q.pop_front();
        c8 = cyc8_q.pop_front();
        check("result8", 66'(if8.result), 66'(e8[7:0]));
        check("carry8", 66'(if8.carry_out), 66'(e8[64]));
        check("ovf8", 66'(if8.overflow), 66'(e8[65]));
        check("done_cycle8", 66'(cyc), 66'(c8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if2.done) begin
      if (exp2_q.size() == 0) begin
        check("unexp_done2", 66'(if2.done), 66'd0);
      end else begin
        e2 = exp2_q.pop_front();
        c2 = cyc2_q.pop_front();
        check("result2", 66'(if2.result), 66'(e2[1:0]));
        check("carry2", 66'(if2.carry_out), 66'(e2[64]));
        check("ovf2", 66'(if2.overflow), 66'(e2[65]));
        check("done_cycle2", 66'(cyc), 66'(c2));
      end
    end
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic wait_idle23();
    int n = 0;
    while (if23.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout23", 66'(if23.busy), 66'd0);
  endtask

  task automatic op23(input logic [22:0] a, input logic [22:0] b, input logic s);
    wait_idle23();
    if23.a = a; if23.b = b; if23.sub = s; if23.start = 1'b1;
    exp23_q.push_back(model(23, 64'(a), 64'(b), s));
    cyc23_q.push_back(cyc + 1 + 23);
    @(negedge clk);
    if23.start = 1'b0;
    if23.a = 23'($urandom);
    if23.b = 23'($urandom);
    if23.sub = 1'($urandom);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    while (if8.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout8", 66'(if8.busy), 66'd0);
    if8.a = a; if8.b = b; if8.sub = s; if8.start = 1'b1;
    exp8_q.push_back(model(8, 64'(a), 64'(b), s));
    cyc8_q.push_back(cyc + 1 + 8);
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic s);
    int n = 0;
    while (if2.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout2", 66'(if2.busy), 66'd0);
    if2.a = a; if2.b = b; if2.sub = s; if2.start = 1'b1;
    exp2_q.push_back(model(2, 64'(a), 64'(b), s));
    cyc2_q.push_back(cyc + 1 + 2);
    @(negedge clk);
    if2.start = 1'b0;
  endtask

  function automatic logic [65:0] outs23();
    return 66'({if23.busy, if23.done, if23.ser_out, if23.ser_valid,
                if23.carry_out, if23.overflow, if23.result});
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    if23.start = 0; if23.sub = 0; if23.a = '0; if23.b = '0;
    if8.start  = 0; if8.sub  = 0; if8.a  = '0; if8.b  = '0;
    if2.start  = 0; if2.sub  = 0; if2.a  = '0; if2.b  = '0;

    #12;
    check("reset_outs23", outs23(), 66'd0);
    check("reset_state23", 66'(if23.dbg_state), 66'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic add / sub / flag cases
    op23(23'd1, 23'd12, 1'b0);
    op23(23'd12, 23'd14, 1'b1);
    op23(23'd14, 23'd12, 1'b1);
    op23(23'h3FFFFF, 23'd1, 1'b0);
    op23(23'h7FFFFF, 23'd1, 1'b0);

    // start during busy is ignored
    op23(23'h001234, 23'h000055, 1'b0);
    repeat (4) @(negedge clk);
    if23.a = 23'h7FFFFF; if23.b = 23'h7FFFFF; if23.sub = 1'b1; if23.start = 1'b1;
    @(negedge clk);
    if23.start = 1'b0;

    // start held through done: next op begins at the edge after done
    op23(23'd100, 23'd200, 1'b0);
    repeat (3) @(negedge clk);
    if23.a = 23'd7; if23.b = 23'd9; if23.sub = 1'b1; if23.start = 1'b1;
    begin
      int n = 0;
      while (if23.done !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("held_done_timeout23", 66'(if23.done), 66'd1);
    end
    exp23_q.push_back(model(23, 64'd7, 64'd9, 1'b1));
    cyc23_q.push_back(cyc + 1 + 23);
    @(negedge clk);
    if23.start = 1'b0;
    wait_idle23();

    // asynchronous reset mid-operation
    op23(23'h2AAAAA, 23'h155555, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs23", outs23(), 66'd0);
    exp23_q.delete();
    cyc23_q.delete();
    if23.start = 1'b1;
    repeat (30) @(negedge clk);
    if23.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs23", outs23(), 66'd0);
    op23(23'h2AAAAA, 23'h155555, 1'b0);

    // random mix
    repeat (8) op23(23'($urandom_range(0, 23'h7FFFFF)), 23'($urandom_range(0, 23'h7FFFFF)),
                    1'($urandom_range(0, 1)));
    wait_idle23();

    // smaller widths
    op8(8'd200, 8'd100, 1'b0);
    op8(8'd100, 8'd200, 1'b1);
    op8(8'd127, 8'd1, 1'b0);
    op8(8'd128, 8'd1, 1'b1);
    op2(2'd1, 2'd1, 1'b0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          op2(2'(a), 2'(b), 1'(s));

    // drain
    begin
      int n = 0;
      while ((exp23_q.size() + exp8_q.size() + exp2_q.size()) != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (30) @(negedge clk);
    end
    check("drain23", 66'(exp23_q.size()), 66'd0);
    check("drain8", 66'(exp8_q.size()), 66'd0);
    check("drain2", 66'(exp2_q.size()), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
